page_rank: RTL and testbench

PAGE_RANK -- requirements
Module: page_rank

---
 rtl/page_rank.sv | 68 ++++++
 tb/tb_page_rank.sv | 115 +++++++++++
 2 files changed

// File: rtl/page_rank.sv
// Single-cycle power-iteration PageRank engine: every node's rank is recomputed
// in parallel each clock from the adjacency matrix and per-node out-link weights.
module page_rank #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*N-1:0]     adj,
    input  logic [N*WIDTH-1:0] nodeWeight,
    output logic [WIDTH-1:0]   node0Val
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    // One spare bit above WIDTH+log2(N) keeps the adder tree clear of overflow.
    localparam int unsigned SUM_W  = WIDTH + $clog2(N) + 1;

    localparam logic [WIDTH:0]   ONE_EXT  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   INIT_EXT = ONE_EXT / (WIDTH + 1)'(N);
    localparam logic [WIDTH-1:0] INIT     = INIT_EXT[WIDTH] ? {WIDTH{1'b1}} : INIT_EXT[WIDTH-1:0];
    localparam logic [SUM_W-1:0] SAT_MAX  = SUM_W'({WIDTH{1'b1}});

    logic [WIDTH-1:0]  r_q    [N];
    logic [WIDTH-1:0]  r_d    [N];
    logic [WIDTH-1:0]  w      [N];
    logic [PROD_W-1:0] prod   [N];
    logic [WIDTH-1:0]  contrib[N];
    logic [SUM_W-1:0]  sum    [N];

    // Per-node outgoing contribution: truncated Q0.WIDTH product of rank and weight.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w[j]       = nodeWeight[j*WIDTH +: WIDTH];
            prod[j]    = PROD_W'(r_q[j]) * PROD_W'(w[j]);
            contrib[j] = prod[j][PROD_W-1:WIDTH];
        end
    end

    // Inbound accumulation per node, saturated back to WIDTH bits.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            sum[i] = '0;
            for (int j = 0; j < N; j++) begin
                if (adj[i*N + j]) begin
                    sum[i] = sum[i] + SUM_W'(contrib[j]);
                end
            end
            if (sum[i] > SAT_MAX) begin
                r_d[i] = {WIDTH{1'b1}};
            end else begin
                r_d[i] = sum[i][WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                r_q[k] <= INIT;
            end else begin
                r_q[k] <= r_d[k];
            end
        end
    end

    assign node0Val = r_q[0];

endmodule

// File: tb/tb_page_rank.sv
// Directed bench for page_rank (N=4, WIDTH=16) with hand-computed node-0 ranks.
module tb_page_rank;

    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 16;

    logic               clk;
    logic               reset;
    logic [N*N-1:0]     adj;
    logic [N*WIDTH-1:0] nodeWeight;
    logic [WIDTH-1:0]   node0Val;

    int n_checks;
    int n_pass;

    page_rank #(.N(N), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .adj        (adj),
        .nodeWeight (nodeWeight),
        .node0Val   (node0Val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: node0Val=0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then sample on the falling edge.
    task automatic step_check(input string tag, input logic [WIDTH-1:0] exp);
        @(posedge clk);
        @(negedge clk);
        check(tag, node0Val, exp);
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset for two edges, checking INIT each time, then release.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        step_check({tag, "_rst0"}, 16'h4000);
        step_check({tag, "_rst1"}, 16'h4000);
        reset = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        // Example graph: 0<-{2,3}, 1<-{0}, 2<-{0,1,3}, 3<-{0,1}
        adj        = 16'h3B1C;
        nodeWeight = {16'h8000, 16'hFFFF, 16'h8000, 16'h5555};
        @(negedge clk);

        do_reset("ex");
        step_check("ex_it1", 16'h5FFF);
        step_check("ex_it2", 16'h6FFE);
        for (int k = 3; k <= 10; k++) step;
        // Mid-run reset restarts from INIT and repeats the sequence.
        reset = 1'b1;
        step_check("ex_midrst", 16'h4000);
        reset = 1'b0;
        step_check("ex_re_it1", 16'h5FFF);
        step_check("ex_re_it2", 16'h6FFE);

        // No edges at all.
        adj = '0;
        do_reset("zero");
        step_check("zero_it1", 16'h0000);
        step_check("zero_it2", 16'h0000);

        // Self-loop on node 0 with weight 1.0 (all-ones) loses one LSB per edge.
        adj        = 16'h0001;
        nodeWeight = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        do_reset("self");
        step_check("self_it1", 16'h3FFF);
        step_check("self_it2", 16'h3FFE);
        step_check("self_it3", 16'h3FFD);

        // Fully connected, all weights 1.0: saturation.
        adj        = 16'hFFFF;
        nodeWeight = {4{16'hFFFF}};
        do_reset("sat");
        step_check("sat_it1", 16'hFFFC);
        step_check("sat_it2", 16'hFFFF);
        step_check("sat_it3", 16'hFFFF);

        // Ring 0->1->2->3->0.
        adj = 16'h4218;
        do_reset("ring");
        step_check("ring_it1", 16'h3FFF);
        step_check("ring_it2", 16'h3FFE);
        step_check("ring_it3", 16'h3FFD);

        // Ring with the 3->0 edge removed: node 0 has no inbound links.
        adj = 16'h4210;
        do_reset("noin");
        step_check("noin_it1", 16'h0000);
        step_check("noin_it2", 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
